// File: rtl/truth_table_lut_n.sv
// ---------------------------------------------------------------------------
// truth_table_lut_n
//
// Registered N-input Boolean function evaluator. The truth table can be
// reprogrammed at run time.
//
// A new table is shifted serially, MSB-first, into a shadow register. It is
// copied into the active table in one step when the last bit arrives.
// Evaluation always reads the active table, so reloading never disturbs
// results that are in flight.
//
// Parameters
//   N        number of function inputs (1..6)
//   TT_INIT  active table after reset; bit i is the output for pattern i
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   ld_start    opens (or restarts) a load session
//   ld_valid    table bit present on ld_bit
//   ld_bit      serial table bit, index 2**N-1 first
//   ld_ready    high while a load session is open
//   ld_done     one-cycle pulse in the cycle after the commit edge
//   in_valid    evaluate inp this cycle
//   inp         input pattern, inp[N-1] is the most significant index bit
//   out         registered function value
//   out_valid   out carries a fresh result
//   programmed  at least one load has committed since reset
//
// Optional feature (macro TT_READBACK_EN)
//   rb_start    snapshot the active table and stream it out MSB-first
//   rb_valid    high for 2**N cycles while the snapshot streams
//   rb_bit      current readback bit
// ---------------------------------------------------------------------------
module truth_table_lut_n #(
   parameter int                N       = 4,
   parameter logic [(1<<N)-1:0] TT_INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld_start,
   input  logic         ld_valid,
   input  logic         ld_bit,
   output logic         ld_ready,
   output logic         ld_done,
   input  logic         in_valid,
   input  logic [N-1:0] inp,
   output logic         out,
   output logic         out_valid,
   output logic         programmed
`ifdef TT_READBACK_EN
  ,input  logic         rb_start,
   output logic         rb_valid,
   output logic         rb_bit
`endif
);

   localparam int DEPTH = 1 << N;
   localparam int CW    = N + 1;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [DEPTH-1:0] shd_reg, shd_next;
   logic [DEPTH-1:0] act_reg, act_next;
   logic             prog_reg, prog_next;
   logic             ld_done_reg, ld_done_next;
   logic             out_reg;
   logic             out_valid_reg;
   logic [DEPTH-1:0] shift_in;

   // Shadow contents after accepting the bit currently on ld_bit. This is
   // also the value committed on the final transfer, so the last bit never
   // has to sit in shd before reaching act.
   assign shift_in = {shd_reg[DEPTH-2:0], ld_bit};

   // ------------------------------------------------------------------
   // Load FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         shd_reg     <= '0;
         act_reg     <= TT_INIT;
         prog_reg    <= 1'b0;
         ld_done_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         shd_reg     <= shd_next;
         act_reg     <= act_next;
         prog_reg    <= prog_next;
         ld_done_reg <= ld_done_next;
      end
   end

   // ------------------------------------------------------------------
   // Load FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      shd_next     = shd_reg;
      act_next     = act_reg;
      prog_next    = prog_reg;
      ld_done_next = 1'b0;

      if (state_reg == IDLE) begin
         if (ld_start) begin
            state_next = LOAD;
            cnt_next   = '0;
            shd_next   = '0;
         end
      end else begin
         // A restart takes priority over a transfer in the same cycle and
         // discards whatever partial table was collected.
         if (ld_start) begin
            cnt_next = '0;
            shd_next = '0;
         end else if (ld_valid) begin
            shd_next = shift_in;
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(DEPTH - 1)) begin
               act_next     = shift_in;
               state_next   = IDLE;
               prog_next    = 1'b1;
               ld_done_next = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Evaluation: reads act_reg before any same-edge commit takes effect
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (in_valid) begin
         out_reg       <= act_reg[inp];
         out_valid_reg <= 1'b1;
      end else begin
         out_valid_reg <= 1'b0;
      end
   end

   assign ld_ready   = (state_reg == LOAD);
   assign ld_done    = ld_done_reg;
   assign out        = out_reg;
   assign out_valid  = out_valid_reg;
   assign programmed = prog_reg;

`ifdef TT_READBACK_EN
   // ------------------------------------------------------------------
   // Readback: a private snapshot means a commit mid-stream cannot change
   // the bits that are already on their way out.
   // ------------------------------------------------------------------
   logic             rb_valid_reg;
   logic [CW-1:0]    rb_left_reg;
   logic [DEPTH-1:0] rb_shift_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         rb_valid_reg <= 1'b0;
         rb_left_reg  <= '0;
         rb_shift_reg <= '0;
      end else if (!rb_valid_reg) begin
         if (rb_start) begin
            rb_shift_reg <= act_reg;
            rb_left_reg  <= CW'(DEPTH - 1);
            rb_valid_reg <= 1'b1;
         end
      end else if (rb_left_reg == '0) begin
         rb_valid_reg <= 1'b0;
      end else begin
         rb_shift_reg <= {rb_shift_reg[DEPTH-2:0], 1'b0};
         rb_left_reg  <= rb_left_reg - CW'(1);
      end
   end

   assign rb_valid = rb_valid_reg;
   assign rb_bit   = rb_shift_reg[DEPTH-1];
`endif

endmodule
